// File: rtl/bsc_ompss_hwcounter_reader.sv
// AXI4-Lite read initiator returning a coherent 64-bit timestamp from a LO/HI counter
// register pair, using a hi/lo/hi read sequence with a bounded number of retries.
module bsc_ompss_hwcounter_reader #(
  parameter int                            C_M_AXI_ADDR_WIDTH  = 32,
  parameter int                            C_M_AXI_DATA_WIDTH  = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_COUNTER_BASE_ADDR = '0,
  parameter int                            C_MAX_RETRIES       = 3
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_areset,
  input  logic                            req_valid,
  output logic                            req_ready,
  output logic                            ts_valid,
  input  logic                            ts_ready,
  output logic [2*C_M_AXI_DATA_WIDTH-1:0] ts_data,
  output logic                            ts_error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);
  localparam int                            DW          = C_M_AXI_DATA_WIDTH;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LO_ADDR     = C_COUNTER_BASE_ADDR;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] HI_ADDR     = C_COUNTER_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4);
  localparam logic [3:0]                    MAX_RETRIES = 4'(C_MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_AR_HI1, S_R_HI1, S_AR_LO, S_R_LO, S_AR_HI2, S_R_HI2, S_DONE
  } state_t;

  state_t                          r_state;
  logic                            r_req_ready;
  logic                            r_ts_valid;
  logic [2*DW-1:0]                 r_ts_data;
  logic                            r_ts_error;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic                            r_arvalid;
  logic                            r_rready;
  logic [3:0]                      r_retries;
  logic [DW-1:0]                   r_hi1;
  logic [DW-1:0]                   r_lo;

  logic w_r_hs;
  logic w_r_err;

  assign w_r_hs  = m_axi_rvalid & r_rready;
  assign w_r_err = (m_axi_rresp != 2'b00);

  assign req_ready     = r_req_ready;
  assign ts_valid      = r_ts_valid;
  assign ts_data       = r_ts_data;
  assign ts_error      = r_ts_error;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_ts_valid  <= 1'b0;
      r_ts_data   <= '0;
      r_ts_error  <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_retries   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_state     <= S_AR_HI1;
          r_req_ready <= 1'b0;
          r_retries   <= '0;
          r_arvalid   <= 1'b1;
          r_araddr    <= HI_ADDR;
        end
        S_AR_HI1: if (m_axi_arready) begin
          r_state <= S_R_HI1; r_arvalid <= 1'b0; r_rready <= 1'b1;
        end
        S_AR_LO: if (m_axi_arready) begin
          r_state <= S_R_LO; r_arvalid <= 1'b0; r_rready <= 1'b1;
        end
        S_AR_HI2: if (m_axi_arready) begin
          r_state <= S_R_HI2; r_arvalid <= 1'b0; r_rready <= 1'b1;
        end
        // Any error response abandons the remaining reads
        S_R_HI1, S_R_LO: if (w_r_hs) begin
          r_rready <= 1'b0;
          if (w_r_err) begin
            r_state <= S_DONE; r_ts_valid <= 1'b1; r_ts_data <= '0; r_ts_error <= 1'b1;
          end else begin
            if (r_state == S_R_HI1) begin
              r_hi1    <= m_axi_rdata;
              r_araddr <= LO_ADDR;
              r_state  <= S_AR_LO;
            end else begin
              r_lo     <= m_axi_rdata;
              r_araddr <= HI_ADDR;
              r_state  <= S_AR_HI2;
            end
            r_arvalid <= 1'b1;
          end
        end
        // On a HI mismatch the second HI becomes the new reference, so only LO is re-read
        S_R_HI2: if (w_r_hs) begin
          r_rready <= 1'b0;
          if (w_r_err) begin
            r_state <= S_DONE; r_ts_valid <= 1'b1; r_ts_data <= '0; r_ts_error <= 1'b1;
          end else if (m_axi_rdata == r_hi1) begin
            r_state <= S_DONE; r_ts_valid <= 1'b1; r_ts_data <= {r_hi1, r_lo}; r_ts_error <= 1'b0;
          end else if (r_retries < MAX_RETRIES) begin
            r_retries <= r_retries + 4'd1;
            r_hi1     <= m_axi_rdata;
            r_araddr  <= LO_ADDR;
            r_arvalid <= 1'b1;
            r_state   <= S_AR_LO;
          end else begin
            r_state    <= S_DONE;
            r_ts_valid <= 1'b1;
            r_ts_data  <= {m_axi_rdata, {DW{1'b0}}};
            r_ts_error <= 1'b1;
          end
        end
        S_DONE: if (ts_ready) begin
          r_state     <= S_IDLE;
          r_ts_valid  <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bsc_ompss_hwcounter_reader.sv
// Bench for bsc_ompss_hwcounter_reader: behavioural AXI-Lite counter responder with
// selectable data behaviour and random stalls, plus per-scenario expected results.
module tb_bsc_ompss_hwcounter_reader;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MAXR = 3;

  logic        clk = 1'b0;
  logic        m_axi_areset;
  logic        req_valid, req_ready, ts_valid, ts_ready, ts_error;
  logic [63:0] ts_data;
  logic [31:0] m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_rresp;

  always #5 clk = ~clk;

  bsc_ompss_hwcounter_reader #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
    .C_COUNTER_BASE_ADDR(BASE), .C_MAX_RETRIES(MAXR)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
    .req_valid(req_valid), .req_ready(req_ready),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data), .ts_error(ts_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Responder configuration and observation log
  int          mode = 0;        // 0 static, 1 HI 5-then-6, 2 HI changes every read, 3 LO error, 4 live counter
  bit          stall_en = 0;
  int          fixed_rd_dly = 0;
  logic [63:0] stat = 64'h0;
  logic [63:0] live = 64'h0;
  logic [31:0] hi_seq = 32'h0;
  int          hi_reads = 0;
  logic [31:0] ar_log[$];

  initial begin : responder
    int          ph, cnt;
    bit          av, rr, rs;
    logic [31:0] aa, cur_addr;
    ph = 0; cnt = 0; cur_addr = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    forever begin
      @(negedge clk);
      av = m_axi_arvalid; rr = m_axi_rready; rs = m_axi_areset; aa = m_axi_araddr;
      if (!rs && ph == 1) begin
        n_chk++;
        if (av !== 1'b1 || aa !== cur_addr) begin
          n_fail++;
          $display("FAIL ar_stable: arvalid=%b araddr=%h, required arvalid=1 araddr=%h", av, aa, cur_addr);
        end
      end
      if (!rs && ph >= 2) begin
        n_chk++;
        if (av !== 1'b0) begin
          n_fail++;
          $display("FAIL ar_while_r: arvalid=%b while read outstanding, required 0", av);
        end
      end
      @(posedge clk); #1;
      live = live + 64'd1;
      if (rs) begin
        ph = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      end else begin
        case (ph)
          0: if (av) begin
            cur_addr = aa;
            cnt = stall_en ? $urandom_range(1, 8) : 1;
            if (cnt == 1) m_axi_arready = 1;
            ph = 1;
          end
          1: if (m_axi_arready && av) begin
            m_axi_arready = 0;
            ar_log.push_back(cur_addr);
            m_axi_rresp = 2'b00;
            if (cur_addr == BASE + 32'd4) begin
              case (mode)
                1:       m_axi_rdata = (hi_reads == 0) ? 32'd5 : 32'd6;
                2:       begin m_axi_rdata = hi_seq; hi_seq = hi_seq + 1; end
                4:       m_axi_rdata = live[63:32];
                default: m_axi_rdata = stat[63:32];
              endcase
              hi_reads++;
            end else begin
              case (mode)
                1:       m_axi_rdata = 32'h10;
                2:       m_axi_rdata = 32'hABCD;
                3:       begin m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b10; end
                4:       m_axi_rdata = live[31:0];
                default: m_axi_rdata = stat[31:0];
              endcase
            end
            cnt = stall_en ? $urandom_range(0, 7) : fixed_rd_dly;
            if (cnt == 0) begin m_axi_rvalid = 1; ph = 3; end
            else ph = 2;
          end else if (!m_axi_arready) begin
            cnt--;
            if (cnt <= 1) m_axi_arready = 1;
          end
          2: begin
            cnt--;
            if (cnt <= 0) begin m_axi_rvalid = 1; ph = 3; end
          end
          default: if (rr) begin m_axi_rvalid = 0; ph = 0; end
        endcase
      end
    end
  end

  // Issues one request; lat = clock edges from req_valid assertion until ts_valid is seen (-1 on timeout)
  task automatic issue(output int lat);
    int n; bit hs;
    lat = -1; hs = 0;
    @(posedge clk); #2; req_valid = 1; n = 0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = req_ready;
      @(posedge clk); n++; #2;
    end
    req_valid = 0;
    if (hs) begin
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (ts_valid === 1'b1) begin lat = n; break; end
        @(posedge clk); n++;
      end
    end
  endtask

  // Holds ts_ready low for 'hold' cycles watching the result, then completes the handshake
  task automatic collect(input int hold, output logic [63:0] d, output logic e, output bit stable);
    d = ts_data; e = ts_error; stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      if (ts_valid !== 1'b1 || ts_data !== d || ts_error !== e) stable = 0;
    end
    @(posedge clk); #2; ts_ready = 1;
    @(posedge clk); #2; ts_ready = 0;
  endtask

  task automatic test_reset();
    m_axi_areset = 1; req_valid = 0; ts_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk += 7;
    if (req_ready !== 1'b1)      begin n_fail++; $display("FAIL rst_req_ready: %b, required 1", req_ready); end
    if (ts_valid !== 1'b0)       begin n_fail++; $display("FAIL rst_ts_valid: %b, required 0", ts_valid); end
    if (ts_data !== 64'h0)       begin n_fail++; $display("FAIL rst_ts_data: %h, required 0", ts_data); end
    if (ts_error !== 1'b0)       begin n_fail++; $display("FAIL rst_ts_error: %b, required 0", ts_error); end
    if (m_axi_arvalid !== 1'b0)  begin n_fail++; $display("FAIL rst_arvalid: %b, required 0", m_axi_arvalid); end
    if (m_axi_rready !== 1'b0)   begin n_fail++; $display("FAIL rst_rready: %b, required 0", m_axi_rready); end
    if (m_axi_araddr !== 32'h0 || m_axi_arprot !== 3'b000) begin
      n_fail++; $display("FAIL rst_araddr: araddr=%h arprot=%b, required 0/000", m_axi_araddr, m_axi_arprot);
    end
    @(posedge clk); #2; m_axi_areset = 0;
  endtask

  task automatic test_static_back_to_back();
    int lat; logic [63:0] d; logic e; bit st;
    mode = 0; stall_en = 0; stat = 64'h0000_0001_0000_0100;
    for (int k = 0; k < 2; k++) begin
      ar_log.delete();
      issue(lat);
      n_chk++;
      if (lat != 10) begin n_fail++; $display("FAIL static_latency[%0d]: %0d cycles, required 10", k, lat); end
      if (lat >= 0) begin
        collect(0, d, e, st);
        n_chk += 3;
        if (d !== stat) begin n_fail++; $display("FAIL static_data[%0d]: %h, required %h", k, d, stat); end
        if (e !== 1'b0) begin n_fail++; $display("FAIL static_error[%0d]: %b, required 0", k, e); end
        if (ar_log.size() != 3) begin n_fail++; $display("FAIL static_beats[%0d]: %0d, required 3", k, ar_log.size()); end
        for (int i = 0; i < ar_log.size(); i++) begin
          n_chk++;
          if (ar_log[i] !== ((i % 2 == 0) ? BASE + 32'd4 : BASE)) begin
            n_fail++; $display("FAIL static_addr[%0d]: %h, required %h", i, ar_log[i], (i % 2 == 0) ? BASE + 32'd4 : BASE);
          end
        end
        @(negedge clk);
        n_chk++;
        if (ts_valid !== 1'b0 || req_ready !== 1'b1) begin
          n_fail++; $display("FAIL after_handshake: ts_valid=%b req_ready=%b, required 0/1", ts_valid, req_ready);
        end
      end
    end
  endtask

  task automatic test_retry_once();
    int lat; logic [63:0] d; logic e; bit st;
    mode = 1; stall_en = 0; hi_reads = 0; ar_log.delete();
    issue(lat);
    n_chk++;
    if (lat < 0) begin n_fail++; $display("FAIL retry1_timeout: no ts_valid, required one"); end
    else begin
      collect(0, d, e, st);
      n_chk += 3;
      if (d !== 64'h0000_0006_0000_0010) begin n_fail++; $display("FAIL retry1_data: %h, required 0000000600000010", d); end
      if (e !== 1'b0) begin n_fail++; $display("FAIL retry1_error: %b, required 0", e); end
      if (ar_log.size() != 5) begin n_fail++; $display("FAIL retry1_beats: %0d, required 5", ar_log.size()); end
      for (int i = 0; i < ar_log.size(); i++) begin
        n_chk++;
        if (ar_log[i] !== ((i % 2 == 0) ? BASE + 32'd4 : BASE)) begin
          n_fail++; $display("FAIL retry1_addr[%0d]: %h, required %h", i, ar_log[i], (i % 2 == 0) ? BASE + 32'd4 : BASE);
        end
      end
    end
  endtask

  task automatic test_retry_exhaust();
    int lat; logic [63:0] d; logic e; bit st; logic [63:0] exp_d;
    mode = 2; stall_en = 0; hi_seq = 32'h20; ar_log.delete();
    // Each attempt reads HI once more; MAXR retries means MAXR+2 HI reads, each a new value
    exp_d = {32'h20 + 32'(MAXR + 1), 32'h0};
    issue(lat);
    n_chk++;
    if (lat < 0) begin n_fail++; $display("FAIL exhaust_timeout: no ts_valid, required one"); end
    else begin
      collect(0, d, e, st);
      n_chk += 3;
      if (d !== exp_d) begin n_fail++; $display("FAIL exhaust_data: %h, required %h", d, exp_d); end
      if (e !== 1'b1) begin n_fail++; $display("FAIL exhaust_error: %b, required 1", e); end
      if (ar_log.size() != 2 * MAXR + 3) begin
        n_fail++; $display("FAIL exhaust_beats: %0d, required %0d", ar_log.size(), 2 * MAXR + 3);
      end
    end
  endtask

  task automatic test_rresp_error();
    int lat; logic [63:0] d; logic e; bit st;
    mode = 3; stall_en = 0; stat = 64'h1234_5678_9ABC_DEF0; ar_log.delete();
    issue(lat);
    n_chk++;
    if (lat < 0) begin n_fail++; $display("FAIL rresp_timeout: no ts_valid, required one"); end
    else begin
      collect(0, d, e, st);
      repeat (6) @(posedge clk);
      @(negedge clk);
      n_chk += 3;
      if (d !== 64'h0) begin n_fail++; $display("FAIL rresp_data: %h, required 0", d); end
      if (e !== 1'b1) begin n_fail++; $display("FAIL rresp_error: %b, required 1", e); end
      if (ar_log.size() != 2) begin n_fail++; $display("FAIL rresp_beats: %0d, required 2", ar_log.size()); end
    end
  endtask

  task automatic test_stalls();
    int lat; logic [63:0] d; logic e; bit st;
    mode = 0; stall_en = 1;
    for (int k = 0; k < 4; k++) begin
      stat = {$urandom, $urandom}; ar_log.delete();
      issue(lat);
      n_chk++;
      if (lat < 0) begin n_fail++; $display("FAIL stall_timeout[%0d]: no ts_valid, required one", k); end
      else begin
        collect(5, d, e, st);
        n_chk += 4;
        if (d !== stat) begin n_fail++; $display("FAIL stall_data[%0d]: %h, required %h", k, d, stat); end
        if (e !== 1'b0) begin n_fail++; $display("FAIL stall_error[%0d]: %b, required 0", k, e); end
        if (st !== 1'b1) begin n_fail++; $display("FAIL stall_ts_stable[%0d]: %b, required 1", k, st); end
        if (ar_log.size() != 3) begin n_fail++; $display("FAIL stall_beats[%0d]: %0d, required 3", k, ar_log.size()); end
      end
    end
    stall_en = 0;
  endtask

  task automatic test_wrap();
    int lat; logic [63:0] d, t0, t1; logic e; bit st;
    mode = 4;
    // First run with ideal timing: LO wraps between the first HI read and the LO read
    for (int k = 0; k < 6; k++) begin
      stall_en = (k != 0);
      ar_log.delete();
      @(posedge clk); #2;
      live = {$urandom, 32'hFFFF_FFFB - ((k == 0) ? 32'd0 : 32'($urandom_range(0, 40)))};
      t0 = live;
      issue(lat);
      n_chk++;
      if (lat < 0) begin n_fail++; $display("FAIL wrap_timeout[%0d]: no ts_valid, required one", k); end
      else begin
        collect(0, d, e, st);
        t1 = live;
        n_chk += 3;
        if (e !== 1'b0) begin n_fail++; $display("FAIL wrap_error[%0d]: %b, required 0", k, e); end
        if (d < t0 || d > t1) begin n_fail++; $display("FAIL wrap_window[%0d]: %h, required in [%h,%h]", k, d, t0, t1); end
        if (ar_log.size() != 3 && ar_log.size() != 5) begin
          n_fail++; $display("FAIL wrap_beats[%0d]: %0d, required 3 or 5", k, ar_log.size());
        end
        if (k == 0) begin
          n_chk += 2;
          if (ar_log.size() != 5) begin n_fail++; $display("FAIL wrap_one_retry: %0d beats, required 5", ar_log.size()); end
          if (d[63:32] !== t0[63:32] + 32'd1) begin
            n_fail++; $display("FAIL wrap_hi: %h, required %h", d[63:32], t0[63:32] + 32'd1);
          end
        end
      end
    end
    stall_en = 0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] d; logic e; bit st; bit seen;
    mode = 0; stall_en = 0; fixed_rd_dly = 3; stat = 64'h0000_00AA_5555_0001; ar_log.delete();
    @(posedge clk); #2; req_valid = 1;
    @(posedge clk); #2; req_valid = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (ar_log.size() == 2);
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL rmid_reach_rlo: LO address beat not seen, required 2 beats"); end
    @(posedge clk); #2; m_axi_areset = 1;
    @(posedge clk); #2; m_axi_areset = 0;
    @(negedge clk);
    n_chk += 2;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_bus: arvalid=%b rready=%b, required 0/0", m_axi_arvalid, m_axi_rready);
    end
    if (ts_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_idle: ts_valid=%b req_ready=%b, required 0/1", ts_valid, req_ready);
    end
    fixed_rd_dly = 0; ar_log.delete();
    issue(lat);
    n_chk++;
    if (lat != 10) begin n_fail++; $display("FAIL rmid_latency: %0d, required 10", lat); end
    if (lat >= 0) begin
      collect(0, d, e, st);
      n_chk += 2;
      if (d !== stat) begin n_fail++; $display("FAIL rmid_data: %h, required %h", d, stat); end
      if (e !== 1'b0) begin n_fail++; $display("FAIL rmid_error: %b, required 0", e); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_static_back_to_back();
    test_retry_once();
    test_retry_exhaust();
    test_rresp_error();
    test_stalls();
    test_wrap();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
